sn74169_ctl: RTL and testbench
==============================

Name: sn74169_ctl

Overview:
- Sequencer sitting directly upstream of the 4-bit synchronous up/down counter stage. It generates that stage's control inputs: preset data A, U_DB, ENPB, ENTB and LOADB.
- It monitors the counter's Q to run one bounded count from a preset value to the terminal value: 0 when counting down, all-ones when counting up.
- It stops the counter exactly on the terminal value, signals completion, and optionally auto-reloads.

Parameters:
- WIDTH, 4, width of the preset/counter value (A, Q, PRESET).
- CYC_W, 8, width of the completed-cycle counter (optional feature only).

Ports:
- CLK  input  1  rising-edge clock, shared with the counter stage.
- RSTB  input  1  asynchronous active-low reset.
- START  input  1  begin a count; sampled only in IDLE.
- STOP  input  1  abort; takes effect in any non-IDLE state.
- PAUSE  input  1  hold the count while high (RUN only).
- AUTO  input  1  reload and restart after completion; sampled in DONE.
- MODE  input  1  1 = count up, 0 = count down; latched on START.
- PRESET  input  WIDTH  start value; latched on START.
- Q  input  WIDTH  counter stage output.
- A  output  WIDTH  preset data to counter stage.
- U_DB  output  1  direction to counter stage.
- ENPB, ENTB  output  1 each  active-low count enables; always driven identically.
- LOADB  output  1  active-low synchronous load.
- BUSY  output  1  high in LOAD, RUN and DONE.
- DONE  output  1  one-cycle completion pulse.

Behaviour:
- All outputs are registered.
- Reset (async, RSTB=0):
  - state=IDLE, A=0, U_DB=0, LOADB=1, ENPB=ENTB=1, BUSY=0, DONE=0, latched preset/mode = 0.
  - Takes effect immediately, including mid-count. The counter is then left holding its value.
- Definitions:
  - TERM = 0 (down) or 2^WIDTH-1 (up).
  - PRE = TERM+1 (down) or TERM-1 (up), i.e. the value one step before TERM.
  - en_now = registered enables currently low.
- IDLE:
  - LOADB=1, enables=1.
  - On START && !STOP → LOAD. Latch PRESET→A and MODE→U_DB, and drive LOADB=0.
- LOAD (1 cycle; the counter captures A on the next edge):
  - If latched preset == TERM → DONE with enables high (zero-length count).
  - Otherwise → RUN with LOADB=1, and enables low unless PAUSE.
- RUN:
  - If en_now && Q==PRE → DONE, enables go high. The counter takes its final step to TERM on this same edge, so there is no overshoot.
  - Otherwise enables(next) = !PAUSE, i.e. ENPB=ENTB=PAUSE. Q==PRE while en_now=0 (paused) does not complete.
- DONE (1 cycle):
  - DONE=1, enables high. Q==TERM throughout this cycle.
  - Next state: if AUTO && !STOP → LOAD using the same latched preset/mode (START not required); else → IDLE.
- STOP:
  - In LOAD, RUN or DONE → IDLE next edge, with enables=1, LOADB=1 and no DONE pulse.
  - STOP dominates START, AUTO and completion when they coincide.
- START while BUSY is ignored.
- PRESET and MODE changes after START have no effect until the next START.
- Count length: a non-trivial run has |PRESET−TERM| enabled edges. DONE rises 3+|PRESET−TERM|−1 edges after the START edge when there is no pause.
- Arithmetic: PRE and TERM are WIDTH-bit; no wrap ever occurs on the counter under control of this block.

Optional Feature:
- Macro: SN74169_CTL_CYCLE_COUNT_EN.
- Defined:
  - Adds output CYCLES [CYC_W-1:0], reset 0.
  - Increments on every DONE pulse and wraps modulo 2^CYC_W.
  - Clears synchronously on START accepted in IDLE.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Down count: PRESET=3, MODE=0, START pulse before edge1.
  - Edge1: LOADB=0, A=3, U_DB=0.
  - Edge2: Q=3, enables low.
  - Edge5: DONE=1, enables high, Q=0.
  - Edge6: IDLE, BUSY=0, Q remains 0.
- Up count: PRESET=13, MODE=1 → Q goes 13, 14, 15. DONE with Q=15, no wrap to 0. Zero-length case: PRESET=15, MODE=1 → DONE one cycle after LOAD, enables never low.
- Pause: PRESET=5 down with PAUSE high for 3 cycles while Q=1 → Q holds 1, no DONE. After PAUSE drops, one enabled edge gives Q=0 and DONE; total run length is 3 cycles longer.
- STOP with AUTO: AUTO=1, PRESET=2 down.
  - After the first DONE, LOAD recurs automatically and Q reloads to 2.
  - Assert STOP together with START mid-RUN at Q=1 → IDLE, no DONE, Q frozen at 1.
- Async reset: drop RSTB mid-RUN between edges → enables=1, LOADB=1, BUSY=0 immediately. After release, START is required to restart.
- SN74169_CTL_CYCLE_COUNT_EN defined: 3 AUTO cycles → CYCLES=3. A new START from IDLE clears it to 0. With CYC_W=2, the fifth cycle wraps CYCLES to 1.

Source files
------------

// File: rtl/sn74169_ctl.sv
// Control sequencer for a 4-bit up/down counter stage: loads a preset, runs one
// bounded count to the terminal value, pulses DONE, optionally auto-reloads.
// Optional completed-cycle counter output enabled by SN74169_CTL_CYCLE_COUNT_EN.
module sn74169_ctl #(
    parameter int WIDTH = 4,
    parameter int CYC_W = 8
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             START,
    input  logic             STOP,
    input  logic             PAUSE,
    input  logic             AUTO,
    input  logic             MODE,
    input  logic [WIDTH-1:0] PRESET,
    input  logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] A,
    output logic             U_DB,
    output logic             ENPB,
    output logic             ENTB,
    output logic             LOADB,
    output logic             BUSY,
    output logic             DONE
`ifdef SN74169_CTL_CYCLE_COUNT_EN
    ,
    output logic [CYC_W-1:0] CYCLES
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_nxt;
    logic             u_db_nxt;
    logic             en_b_q, en_b_nxt;
    logic             loadb_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             start_ok;
    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] pre_val;

    function automatic logic [WIDTH-1:0] term_of(input logic up);
        return up ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    endfunction

    // One step before terminal: all-ones-minus-one when up, one when down.
    function automatic logic [WIDTH-1:0] pre_of(input logic up);
        return up ? {{(WIDTH-1){1'b1}}, 1'b0} : {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    assign term_val = term_of(U_DB);
    assign pre_val  = pre_of(U_DB);
    assign start_ok = (state == S_IDLE) && START && !STOP;

    always_comb begin
        state_nxt = state;
        a_nxt     = A;
        u_db_nxt  = U_DB;
        en_b_nxt  = 1'b1;
        loadb_nxt = 1'b1;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_nxt = S_LOAD;
                    a_nxt     = PRESET;
                    u_db_nxt  = MODE;
                    loadb_nxt = 1'b0;
                end
            end
            S_LOAD: begin
                if (STOP) begin
                    state_nxt = S_IDLE;
                end else if (A == term_val) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = S_RUN;
                    en_b_nxt  = PAUSE;
                end
            end
            S_RUN: begin
                // Stop on the edge where the counter steps from PRE to TERM.
                if (STOP) begin
                    state_nxt = S_IDLE;
                end else if (!en_b_q && (Q == pre_val)) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                end else begin
                    en_b_nxt  = PAUSE;
                end
            end
            S_DONE: begin
                if (AUTO && !STOP) begin
                    state_nxt = S_LOAD;
                    loadb_nxt = 1'b0;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state  <= S_IDLE;
            A      <= '0;
            U_DB   <= 1'b0;
            en_b_q <= 1'b1;
            LOADB  <= 1'b1;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            state  <= state_nxt;
            A      <= a_nxt;
            U_DB   <= u_db_nxt;
            en_b_q <= en_b_nxt;
            LOADB  <= loadb_nxt;
            BUSY   <= busy_nxt;
            DONE   <= done_nxt;
        end
    end

    assign ENPB = en_b_q;
    assign ENTB = en_b_q;

`ifdef SN74169_CTL_CYCLE_COUNT_EN
    // Advances on the same edge DONE rises, so it reads the new total during the pulse.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            CYCLES <= '0;
        end else if (start_ok) begin
            CYCLES <= '0;
        end else if (done_nxt) begin
            CYCLES <= CYCLES + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sn74169_ctl.sv
// Directed bench for sn74169_ctl with a behavioural model of the counter stage
// closing the loop from A/U_DB/ENPB/ENTB/LOADB back to Q.
module tb_sn74169_ctl;

    logic       CLK;
    logic       RSTB;
    logic       START, STOP, PAUSE, AUTO, MODE;
    logic [3:0] PRESET;
    logic [3:0] Q;
    logic [3:0] A;
    logic       U_DB, ENPB, ENTB, LOADB, BUSY, DONE;
`ifdef SN74169_CTL_CYCLE_COUNT_EN
    logic [1:0] CYCLES;
`endif

    int vectors = 0;
    int fails   = 0;

    sn74169_ctl #(.WIDTH(4), .CYC_W(2)) dut (
        .CLK    (CLK),
        .RSTB   (RSTB),
        .START  (START),
        .STOP   (STOP),
        .PAUSE  (PAUSE),
        .AUTO   (AUTO),
        .MODE   (MODE),
        .PRESET (PRESET),
        .Q      (Q),
        .A      (A),
        .U_DB   (U_DB),
        .ENPB   (ENPB),
        .ENTB   (ENTB),
        .LOADB  (LOADB),
        .BUSY   (BUSY),
        .DONE   (DONE)
`ifdef SN74169_CTL_CYCLE_COUNT_EN
        ,
        .CYCLES (CYCLES)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Counter stage: synchronous load, active-low enables, U_DB=1 counts up.
    initial Q = 4'd0;
    always @(posedge CLK) begin
        if (!LOADB)
            Q <= A;
        else if (!ENPB && !ENTB)
            Q <= U_DB ? Q + 4'd1 : Q - 4'd1;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_pulse(input logic [3:0] pre, input logic md);
        PRESET = pre;
        MODE   = md;
        START  = 1'b1;
        tick();
        START  = 1'b0;
    endtask

    initial begin
        RSTB = 1'b0; START = 1'b0; STOP = 1'b0; PAUSE = 1'b0; AUTO = 1'b0;
        MODE = 1'b0; PRESET = 4'd0;
        tick();
        chk("rst_A", {4'd0, A}, 8'h0);
        chk("rst_UDB", {7'd0, U_DB}, 8'h0);
        chk("rst_LOADB", {7'd0, LOADB}, 8'h1);
        chk("rst_ENPB", {7'd0, ENPB}, 8'h1);
        chk("rst_ENTB", {7'd0, ENTB}, 8'h1);
        chk("rst_BUSY", {7'd0, BUSY}, 8'h0);
        chk("rst_DONE", {7'd0, DONE}, 8'h0);
        tick();
        RSTB = 1'b1;
        tick();

        // Down count from 3: DONE on edge 5 with Q=0
        start_pulse(4'd3, 1'b0);                             // edge 1
        chk("dn_e1_LOADB", {7'd0, LOADB}, 8'h0);
        chk("dn_e1_A", {4'd0, A}, 8'h3);
        chk("dn_e1_UDB", {7'd0, U_DB}, 8'h0);
        chk("dn_e1_BUSY", {7'd0, BUSY}, 8'h1);
        PRESET = 4'd9; MODE = 1'b1;
        tick();                                              // edge 2
        chk("dn_e2_Q", {4'd0, Q}, 8'h3);
        chk("dn_e2_ENPB", {7'd0, ENPB}, 8'h0);
        chk("dn_e2_ENTB", {7'd0, ENTB}, 8'h0);
        chk("dn_e2_LOADB", {7'd0, LOADB}, 8'h1);
        START = 1'b1;
        tick();                                              // edge 3, START ignored
        START = 1'b0;
        chk("dn_e3_Q", {4'd0, Q}, 8'h2);
        chk("dn_e3_LOADB", {7'd0, LOADB}, 8'h1);
        chk("dn_e3_A", {4'd0, A}, 8'h3);
        tick();                                              // edge 4
        chk("dn_e4_Q", {4'd0, Q}, 8'h1);
        chk("dn_e4_DONE", {7'd0, DONE}, 8'h0);
        tick();                                              // edge 5
        chk("dn_e5_DONE", {7'd0, DONE}, 8'h1);
        chk("dn_e5_ENPB", {7'd0, ENPB}, 8'h1);
        chk("dn_e5_Q", {4'd0, Q}, 8'h0);
        tick();                                              // edge 6
        chk("dn_e6_BUSY", {7'd0, BUSY}, 8'h0);
        chk("dn_e6_DONE", {7'd0, DONE}, 8'h0);
        chk("dn_e6_Q", {4'd0, Q}, 8'h0);
        tick();

        // Up count from 13: DONE on edge 4 with Q=15, no wrap afterwards
        start_pulse(4'd13, 1'b1);                            // edge 1
        tick();                                              // edge 2
        chk("up_e2_Q", {4'd0, Q}, 8'hd);
        tick();                                              // edge 3
        chk("up_e3_Q", {4'd0, Q}, 8'he);
        chk("up_e3_DONE", {7'd0, DONE}, 8'h0);
        tick();                                              // edge 4
        chk("up_e4_DONE", {7'd0, DONE}, 8'h1);
        chk("up_e4_Q", {4'd0, Q}, 8'hf);
        tick();                                              // edge 5
        chk("up_e5_Q", {4'd0, Q}, 8'hf);
        chk("up_e5_BUSY", {7'd0, BUSY}, 8'h0);

        // Zero-length: preset already at terminal
        start_pulse(4'd15, 1'b1);                            // edge 1
        chk("z_e1_LOADB", {7'd0, LOADB}, 8'h0);
        chk("z_e1_ENPB", {7'd0, ENPB}, 8'h1);
        tick();                                              // edge 2
        chk("z_e2_DONE", {7'd0, DONE}, 8'h1);
        chk("z_e2_ENPB", {7'd0, ENPB}, 8'h1);
        chk("z_e2_Q", {4'd0, Q}, 8'hf);
        tick();                                              // edge 3
        chk("z_e3_BUSY", {7'd0, BUSY}, 8'h0);
        chk("z_e3_Q", {4'd0, Q}, 8'hf);

        // Pause from 5 down: held at Q=1 for 3 cycles, DONE on edge 10 instead of 7
        start_pulse(4'd5, 1'b0);                             // edge 1
        tick(); tick(); tick(); tick();                      // edges 2..5
        chk("p_e5_Q", {4'd0, Q}, 8'h2);
        PAUSE = 1'b1;
        tick();                                              // edge 6
        chk("p_e6_Q", {4'd0, Q}, 8'h1);
        chk("p_e6_ENPB", {7'd0, ENPB}, 8'h1);
        tick();                                              // edge 7
        chk("p_e7_Q", {4'd0, Q}, 8'h1);
        chk("p_e7_DONE", {7'd0, DONE}, 8'h0);
        tick();                                              // edge 8
        chk("p_e8_Q", {4'd0, Q}, 8'h1);
        chk("p_e8_DONE", {7'd0, DONE}, 8'h0);
        PAUSE = 1'b0;
        tick();                                              // edge 9
        chk("p_e9_Q", {4'd0, Q}, 8'h1);
        chk("p_e9_DONE", {7'd0, DONE}, 8'h0);
        chk("p_e9_ENPB", {7'd0, ENPB}, 8'h0);
        tick();                                              // edge 10
        chk("p_e10_DONE", {7'd0, DONE}, 8'h1);
        chk("p_e10_Q", {4'd0, Q}, 8'h0);
        tick();
        chk("p_e11_BUSY", {7'd0, BUSY}, 8'h0);

        // AUTO reload from 2 down, then STOP+START mid-run
        AUTO = 1'b1;
        start_pulse(4'd2, 1'b0);                             // edge 1
        tick(); tick();                                      // edges 2,3
        chk("a_e3_Q", {4'd0, Q}, 8'h1);
        tick();                                              // edge 4
        chk("a_e4_DONE", {7'd0, DONE}, 8'h1);
        chk("a_e4_Q", {4'd0, Q}, 8'h0);
        tick();                                              // edge 5: auto LOAD
        chk("a_e5_LOADB", {7'd0, LOADB}, 8'h0);
        chk("a_e5_BUSY", {7'd0, BUSY}, 8'h1);
        chk("a_e5_DONE", {7'd0, DONE}, 8'h0);
        tick();                                              // edge 6
        chk("a_e6_Q", {4'd0, Q}, 8'h2);
        STOP = 1'b1; START = 1'b1;
        tick();                                              // edge 7
        chk("s_e7_BUSY", {7'd0, BUSY}, 8'h0);
        chk("s_e7_DONE", {7'd0, DONE}, 8'h0);
        chk("s_e7_ENPB", {7'd0, ENPB}, 8'h1);
        chk("s_e7_LOADB", {7'd0, LOADB}, 8'h1);
        chk("s_e7_Q", {4'd0, Q}, 8'h1);
        tick();                                              // edge 8: STOP blocks START in IDLE
        chk("s_e8_BUSY", {7'd0, BUSY}, 8'h0);
        chk("s_e8_LOADB", {7'd0, LOADB}, 8'h1);
        STOP = 1'b0; START = 1'b0; AUTO = 1'b0;
        tick(); tick();
        chk("s_e10_Q", {4'd0, Q}, 8'h1);
        chk("s_e10_DONE", {7'd0, DONE}, 8'h0);

        // Asynchronous reset mid-run
        start_pulse(4'd6, 1'b0);                             // edge 1
        tick(); tick();                                      // edges 2,3
        chk("r_e3_Q", {4'd0, Q}, 8'h5);
        #3 RSTB = 1'b0;
        #1;
        chk("r_ENPB", {7'd0, ENPB}, 8'h1);
        chk("r_ENTB", {7'd0, ENTB}, 8'h1);
        chk("r_LOADB", {7'd0, LOADB}, 8'h1);
        chk("r_BUSY", {7'd0, BUSY}, 8'h0);
        chk("r_A", {4'd0, A}, 8'h0);
        tick();
        RSTB = 1'b1;
        tick(); tick();
        chk("r_hold_Q", {4'd0, Q}, 8'h5);
        chk("r_idle_BUSY", {7'd0, BUSY}, 8'h0);
        chk("r_idle_LOADB", {7'd0, LOADB}, 8'h1);
        start_pulse(4'd4, 1'b0);
        chk("r_restart_LOADB", {7'd0, LOADB}, 8'h0);
        chk("r_restart_A", {4'd0, A}, 8'h4);
        tick(); tick(); tick(); tick();                      // edges 2..5: Q 4,3,2,1
        tick();                                              // edge 6: DONE
        chk("r_restart_DONE", {7'd0, DONE}, 8'h1);
        chk("r_restart_Q", {4'd0, Q}, 8'h0);
        tick();

`ifdef SN74169_CTL_CYCLE_COUNT_EN
        // Preset 1 down with AUTO: DONE every 3 edges (3, 6, 9, ...)
        AUTO = 1'b1;
        start_pulse(4'd1, 1'b0);                             // edge 1
        chk("c_clr0", {6'd0, CYCLES}, 8'h0);
        tick(); tick();                                      // edge 3
        chk("c_1", {6'd0, CYCLES}, 8'h1);
        tick(); tick(); tick(); tick(); tick(); tick();      // edge 9
        chk("c_3_DONE", {7'd0, DONE}, 8'h1);
        chk("c_3", {6'd0, CYCLES}, 8'h3);
        AUTO = 1'b0;
        tick();
        chk("c_idle", {6'd0, CYCLES}, 8'h3);
        AUTO = 1'b1;
        start_pulse(4'd1, 1'b0);                             // edge 1
        chk("c_clr", {6'd0, CYCLES}, 8'h0);
        for (int i = 0; i < 11; i++) tick();                 // edge 12
        chk("c_4_wrap", {6'd0, CYCLES}, 8'h0);
        tick(); tick(); tick();                              // edge 15
        chk("c_5", {6'd0, CYCLES}, 8'h1);
        AUTO = 1'b0;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
